// File: rtl/decode_wb_pipe_if.sv
// Decode/write-back stage bus: D fields, forwarding and write-back
// sources in, E pipeline register, stall and ready out.
interface decode_wb_pipe_if #(
   parameter int DATA_W = 64,
   parameter int REG_AW = 4
);
   logic [3:0]        D_icode_i;
   logic [REG_AW-1:0] D_rA_i;
   logic [REG_AW-1:0] D_rB_i;
   logic [DATA_W-1:0] D_valP_i;
   logic [REG_AW-1:0] e_dstE_i;
   logic [DATA_W-1:0] e_valE_i;
   logic [REG_AW-1:0] E_dstM_i;
   logic [REG_AW-1:0] M_dstM_i;
   logic [DATA_W-1:0] m_valM_i;
   logic [REG_AW-1:0] M_dstE_i;
   logic [DATA_W-1:0] M_valE_i;
   logic [REG_AW-1:0] W_dstM_i;
   logic [DATA_W-1:0] W_valM_i;
   logic [REG_AW-1:0] W_dstE_i;
   logic [DATA_W-1:0] W_valE_i;
   logic              bubble_i;
   logic              stall_o;
   logic              ready_o;
   logic [3:0]        E_icode_o;
   logic [DATA_W-1:0] E_valA_o;
   logic [DATA_W-1:0] E_valB_o;
   logic [REG_AW-1:0] E_srcA_o;
   logic [REG_AW-1:0] E_srcB_o;
   logic [REG_AW-1:0] E_dstE_o;
   logic [REG_AW-1:0] E_dstM_o;

   modport master (
      output D_icode_i, D_rA_i, D_rB_i, D_valP_i,
      output e_dstE_i, e_valE_i, E_dstM_i,
      output M_dstM_i, m_valM_i, M_dstE_i, M_valE_i,
      output W_dstM_i, W_valM_i, W_dstE_i, W_valE_i,
      output bubble_i,
      input  stall_o, ready_o, E_icode_o,
      input  E_valA_o, E_valB_o,
      input  E_srcA_o, E_srcB_o, E_dstE_o, E_dstM_o
   );

   modport slave (
      input  D_icode_i, D_rA_i, D_rB_i, D_valP_i,
      input  e_dstE_i, e_valE_i, E_dstM_i,
      input  M_dstM_i, m_valM_i, M_dstE_i, M_valE_i,
      input  W_dstM_i, W_valM_i, W_dstE_i, W_valE_i,
      input  bubble_i,
      output stall_o, ready_o, E_icode_o,
      output E_valA_o, E_valB_o,
      output E_srcA_o, E_srcB_o, E_dstE_o, E_dstM_o
   );
endinterface

// File: rtl/decode_wb_pipe.sv
// Y86-64 decode/write-back stage: register file, forwarding,
// load/use detection, D->E register and post-reset clear.
module decode_wb_pipe #(
   parameter int                 DATA_W = 64,
   parameter int                 NREGS  = 15,
   parameter int                 REG_AW = 4,
   parameter logic [REG_AW-1:0] RNONE  = 4'hF
) (
   input logic             clk_i,
   input logic             rst_i,
   decode_wb_pipe_if.slave p
);

   localparam logic [3:0] I_HALT   = 4'h0;
   localparam logic [3:0] I_NOP    = 4'h1;
   localparam logic [3:0] I_CMOVQ  = 4'h2;
   localparam logic [3:0] I_IRMOVQ = 4'h3;
   localparam logic [3:0] I_RMMOVQ = 4'h4;
   localparam logic [3:0] I_MRMOVQ = 4'h5;
   localparam logic [3:0] I_OPQ    = 4'h6;
   localparam logic [3:0] I_JXX    = 4'h7;
   localparam logic [3:0] I_CALL   = 4'h8;
   localparam logic [3:0] I_RET    = 4'h9;
   localparam logic [3:0] I_PUSHQ  = 4'hA;
   localparam logic [3:0] I_POPQ   = 4'hB;

   localparam logic [REG_AW-1:0] RSP  = REG_AW'(4);
   localparam logic [REG_AW-1:0] LAST = REG_AW'(NREGS - 1);
   localparam logic [REG_AW:0]   NR_W = (REG_AW + 1)'(NREGS);

   typedef struct packed {
      logic [3:0]        icode;
      logic [DATA_W-1:0] valA;
      logic [DATA_W-1:0] valB;
      logic [REG_AW-1:0] srcA;
      logic [REG_AW-1:0] srcB;
      logic [REG_AW-1:0] dstE;
      logic [REG_AW-1:0] dstM;
   } id_ex_t;

   typedef enum logic {CLEAR, RUN} state_t;

   state_t            state;
   logic [REG_AW-1:0] idx;
   logic [DATA_W-1:0] regs [NREGS];

   logic [REG_AW-1:0] srcA, srcB, dstE, dstM;
   logic [DATA_W-1:0] rf_a, rf_b, valA, valB;
   logic              ready, hazard;
   logic              we_e, we_m;
   id_ex_t            e_d, e_q;

   function automatic logic in_rng(input logic [REG_AW-1:0] r);
      return (r != RNONE) && ({1'b0, r} < NR_W);
   endfunction

   always_comb begin
      srcA = RNONE;
      srcB = RNONE;
      dstE = RNONE;
      dstM = RNONE;
      unique case (p.D_icode_i)
         I_CMOVQ:  begin srcA = p.D_rA_i; dstE = p.D_rB_i; end
         I_IRMOVQ: dstE = p.D_rB_i;
         I_RMMOVQ: begin srcA = p.D_rA_i; srcB = p.D_rB_i; end
         I_MRMOVQ: begin srcB = p.D_rB_i; dstM = p.D_rA_i; end
         I_OPQ: begin
            srcA = p.D_rA_i;
            srcB = p.D_rB_i;
            dstE = p.D_rB_i;
         end
         I_PUSHQ: begin srcA = p.D_rA_i; srcB = RSP; dstE = RSP; end
         I_POPQ: begin
            srcA = RSP;
            srcB = RSP;
            dstE = RSP;
            dstM = p.D_rA_i;
         end
         I_CALL: begin srcB = RSP; dstE = RSP; end
         I_RET:  begin srcA = RSP; srcB = RSP; dstE = RSP; end
         default: ;
      endcase
   end

   assign rf_a = in_rng(srcA) ? regs[srcA] : '0;
   assign rf_b = in_rng(srcB) ? regs[srcB] : '0;

   // Youngest producer wins; RNONE sources fall through to the 0 read.
   always_comb begin
      valA = rf_a;
      if (p.D_icode_i == I_CALL || p.D_icode_i == I_JXX)
         valA = p.D_valP_i;
      else if (srcA != RNONE) begin
         if (srcA == p.e_dstE_i)      valA = p.e_valE_i;
         else if (srcA == p.M_dstM_i) valA = p.m_valM_i;
         else if (srcA == p.M_dstE_i) valA = p.M_valE_i;
         else if (srcA == p.W_dstM_i) valA = p.W_valM_i;
         else if (srcA == p.W_dstE_i) valA = p.W_valE_i;
      end
   end

   always_comb begin
      valB = rf_b;
      if (srcB != RNONE) begin
         if (srcB == p.e_dstE_i)      valB = p.e_valE_i;
         else if (srcB == p.M_dstM_i) valB = p.m_valM_i;
         else if (srcB == p.M_dstE_i) valB = p.M_valE_i;
         else if (srcB == p.W_dstM_i) valB = p.W_valM_i;
         else if (srcB == p.W_dstE_i) valB = p.W_valE_i;
      end
   end

   assign hazard = (p.E_dstM_i != RNONE) &&
                   (p.E_dstM_i == srcA || p.E_dstM_i == srcB);
   assign ready  = (state == RUN);
   assign we_e   = in_rng(p.W_dstE_i);
   assign we_m   = in_rng(p.W_dstM_i);

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state <= CLEAR;
         idx   <= '0;
      end else if (state == CLEAR) begin
         idx <= idx + 1'b1;
         if (idx == LAST)
            state <= RUN;
      end
   end

   // valM is written last so it wins a same-register collision.
   always_ff @(posedge clk_i) begin
      if (state == CLEAR)
         regs[idx] <= '0;
      else begin
         if (we_e) regs[p.W_dstE_i] <= p.W_valE_i;
         if (we_m) regs[p.W_dstM_i] <= p.W_valM_i;
      end
   end

   always_comb begin
      e_d.icode = p.D_icode_i;
      e_d.valA  = valA;
      e_d.valB  = valB;
      e_d.srcA  = srcA;
      e_d.srcB  = srcB;
      e_d.dstE  = dstE;
      e_d.dstM  = dstM;
      if (rst_i || !ready || hazard || p.bubble_i) begin
         e_d.icode = I_NOP;
         e_d.valA  = '0;
         e_d.valB  = '0;
         e_d.srcA  = RNONE;
         e_d.srcB  = RNONE;
         e_d.dstE  = RNONE;
         e_d.dstM  = RNONE;
      end
   end

   always_ff @(posedge clk_i) begin
      e_q <= e_d;
   end

   assign p.stall_o   = hazard | ~ready;
   assign p.ready_o   = ready;
   assign p.E_icode_o = e_q.icode;
   assign p.E_valA_o  = e_q.valA;
   assign p.E_valB_o  = e_q.valB;
   assign p.E_srcA_o  = e_q.srcA;
   assign p.E_srcB_o  = e_q.srcB;
   assign p.E_dstE_o  = e_q.dstE;
   assign p.E_dstM_o  = e_q.dstM;

   logic unused_halt;
   assign unused_halt = (I_HALT == 4'h0);

endmodule
